// File: rtl/cursor_input_ctrl.sv
// rtl/cursor_input_ctrl.sv - button conditioning, auto-repeat and cursor position tracking
module cursor_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 40000000,
    parameter int REPEAT_RATE     = 15000000,
    parameter int GRID_COLS       = 16,
    parameter int GRID_ROWS       = 12,
    parameter int CELL_PX         = 32,
    parameter int X0              = 64,
    parameter int Y0              = 48
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       right,
    input  logic       left,
    input  logic       up,
    input  logic       down,
    input  logic       flip,
    input  logic       enable,
    output logic [9:0] x_topleft,
    output logic [8:0] y_topleft,
    output logic [7:0] cell_id,
    output logic       flip_pulse,
    output logic       moved
);

    // Button index doubles as direction priority: lower index wins.
    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_FLIP  = 4;

    localparam int CW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam int COLW = (GRID_COLS > 2) ? $clog2(GRID_COLS) : 1;
    localparam int ROWW = (GRID_ROWS > 2) ? $clog2(GRID_ROWS) : 1;

    localparam logic [CW-1:0]   DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]   T_DELAY   = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0]   T_RATE    = TW'(REPEAT_RATE - 1);
    localparam logic [COLW-1:0] COL_LAST  = COLW'(GRID_COLS - 1);
    localparam logic [ROWW-1:0] ROW_LAST  = ROWW'(GRID_ROWS - 1);
    localparam logic [9:0]      X_STEP    = 10'(CELL_PX);
    localparam logic [8:0]      Y_STEP    = 9'(CELL_PX);
    localparam logic [7:0]      ROW_STEP  = 8'(GRID_COLS);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic [4:0]    raw;
    logic [4:0]    sync1;
    logic [4:0]    sync2;
    logic [4:0]    stable;
    logic [4:0]    stable_d;
    logic [4:0]    press;
    logic [CW-1:0] db_cnt [5];

    state_t          state;
    logic [1:0]      active_dir;
    logic [TW-1:0]   timer;
    logic [COLW-1:0] col;
    logic [ROWW-1:0] row;

    logic       step;
    logic [1:0] sel_dir;
    logic       in_bounds;

    assign raw   = {flip, up, down, left, right};
    assign press = stable & ~stable_d;

    // Two-flop synchronizer and per-button debounce counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int b = 0; b < 5; b++) db_cnt[b] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            for (int b = 0; b < 5; b++) begin
                if (sync2[b] == stable[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_LAST) begin
                    stable[b] <= sync2[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + 1'b1;
                end
            end
        end
    end

    // Decide whether a move is due this cycle, in which direction, and whether it stays on the board.
    always_comb begin
        step      = 1'b0;
        sel_dir   = active_dir;
        in_bounds = 1'b0;
        if (state == IDLE) begin
            if (press[BTN_RIGHT]) begin
                step = 1'b1; sel_dir = 2'(BTN_RIGHT);
            end else if (press[BTN_LEFT]) begin
                step = 1'b1; sel_dir = 2'(BTN_LEFT);
            end else if (press[BTN_DOWN]) begin
                step = 1'b1; sel_dir = 2'(BTN_DOWN);
            end else if (press[BTN_UP]) begin
                step = 1'b1; sel_dir = 2'(BTN_UP);
            end
        end else if (stable[active_dir] && timer == '0) begin
            step = 1'b1;
        end
        case (sel_dir)
            2'd0:    in_bounds = (col != COL_LAST);
            2'd1:    in_bounds = (col != '0);
            2'd2:    in_bounds = (row != ROW_LAST);
            default: in_bounds = (row != '0);
        endcase
    end

    // Auto-repeat FSM plus incrementally maintained position registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            active_dir <= '0;
            timer      <= '0;
            col        <= '0;
            row        <= '0;
            x_topleft  <= 10'(X0);
            y_topleft  <= 9'(Y0);
            cell_id    <= '0;
            flip_pulse <= 1'b0;
            moved      <= 1'b0;
        end else begin
            moved      <= 1'b0;
            flip_pulse <= press[BTN_FLIP] & enable;
            case (state)
                IDLE: begin
                    if (step) begin
                        active_dir <= sel_dir;
                        timer      <= T_DELAY;
                        state      <= DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    if (!stable[active_dir]) begin
                        state <= IDLE;
                    end else if (timer == '0) begin
                        timer <= T_RATE;
                        state <= REPEAT;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (step && enable && in_bounds) begin
                moved <= 1'b1;
                case (sel_dir)
                    2'd0: begin
                        col       <= col + 1'b1;
                        x_topleft <= x_topleft + X_STEP;
                        cell_id   <= cell_id + 1'b1;
                    end
                    2'd1: begin
                        col       <= col - 1'b1;
                        x_topleft <= x_topleft - X_STEP;
                        cell_id   <= cell_id - 1'b1;
                    end
                    2'd2: begin
                        row       <= row + 1'b1;
                        y_topleft <= y_topleft + Y_STEP;
                        cell_id   <= cell_id + ROW_STEP;
                    end
                    default: begin
                        row       <= row - 1'b1;
                        y_topleft <= y_topleft - Y_STEP;
                        cell_id   <= cell_id - ROW_STEP;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cursor_input_ctrl.sv
// tb/tb_cursor_input_ctrl.sv - self-checking bench for cursor_input_ctrl
module tb_cursor_input_ctrl;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RR = 8;

    logic       clock;
    logic       reset;
    logic       right, left, up, down, flip, enable;
    logic [9:0] x_topleft;
    logic [8:0] y_topleft;
    logic [7:0] cell_id;
    logic       flip_pulse;
    logic       moved;

    cursor_input_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .right(right),
        .left(left),
        .up(up),
        .down(down),
        .flip(flip),
        .enable(enable),
        .x_topleft(x_topleft),
        .y_topleft(y_topleft),
        .cell_id(cell_id),
        .flip_pulse(flip_pulse),
        .moved(moved)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;
    int mcount   = 0;
    int fcount   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a button's clean level flips once D consecutive samples (taken two
    // edges earlier) disagree with it; moves follow a press at fixed offsets.
    logic [4:0] samp [$];
    logic [4:0] m_stable = '0;
    logic [4:0] m_prev   = '0;
    logic [4:0] pr;
    int  cyc = 0;
    int  m_active = -1;
    int  m_first = 0;
    int  m_col = 0;
    int  m_row = 0;
    bit  m_moved = 1'b0;
    bit  m_flip = 1'b0;
    int  dir, el, nc, nr;
    bit  mv, all_diff;

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            samp.delete();
            samp.push_back(5'b0);
            m_stable = '0;
            m_prev   = '0;
            m_active = -1;
            m_col    = 0;
            m_row    = 0;
            m_moved  = 1'b0;
            m_flip   = 1'b0;
        end else begin
            pr  = m_stable & ~m_prev;
            mv  = 1'b0;
            dir = -1;
            if (m_active >= 0) begin
                if (!m_stable[m_active]) begin
                    m_active = -1;
                end else begin
                    el = cyc - m_first;
                    if (el == RD || (el > RD && (el - RD) % RR == 0)) begin
                        mv  = 1'b1;
                        dir = m_active;
                    end
                end
            end else begin
                for (int b = 3; b >= 0; b--) if (pr[b]) dir = b;
                if (dir >= 0) begin
                    m_active = dir;
                    m_first  = cyc;
                    mv       = 1'b1;
                end
            end
            m_moved = 1'b0;
            if (mv && enable) begin
                nc = m_col;
                nr = m_row;
                case (dir)
                    0: nc++;
                    1: nc--;
                    2: nr++;
                    default: nr--;
                endcase
                if (nc < 0) nc = 0;
                if (nc > 15) nc = 15;
                if (nr < 0) nr = 0;
                if (nr > 11) nr = 11;
                if (nc != m_col || nr != m_row) begin
                    m_moved = 1'b1;
                    m_col   = nc;
                    m_row   = nr;
                end
            end
            m_flip = pr[4] && enable;
            m_prev = m_stable;
            for (int b = 0; b < 5; b++) begin
                if (samp.size() >= D + 1) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < D; k++)
                        if (samp[samp.size() - 2 - k][b] == m_stable[b]) all_diff = 1'b0;
                    if (all_diff) m_stable[b] = ~m_stable[b];
                end
            end
            samp.push_back({flip, up, down, left, right});
            if (samp.size() > D + 2) void'(samp.pop_front());
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (checking) begin
            check("x_topleft", int'(x_topleft), 64 + m_col * 32);
            check("y_topleft", int'(y_topleft), 48 + m_row * 32);
            check("cell_id", int'(cell_id), m_row * 16 + m_col);
            check("flip_pulse", int'(flip_pulse), int'(m_flip));
            check("moved", int'(moved), int'(m_moved));
        end
    end

    always @(posedge clock) begin
        #1;
        if (moved) mcount++;
        if (flip_pulse) fcount++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(2);
    endtask

    int m0, f0;

    initial begin
        reset = 1'b1;
        right = 0; left = 0; up = 0; down = 0; flip = 0; enable = 1;
        tick(1);
        checking = 1'b1;
        tick(1);
        reset = 1'b0;

        // 1: reset state
        tick(10);
        check("t1_x", int'(x_topleft), 64);
        check("t1_y", int'(y_topleft), 48);
        check("t1_cell", int'(cell_id), 0);
        check("t1_flip", int'(flip_pulse), 0);
        check("t1_moved", int'(moved), 0);

        // 2: glitch then a single clean press
        right = 1; tick(2); right = 0; tick(6);
        m0 = mcount;
        right = 1;
        tick(6);
        check("t2_moved_early", int'(moved), 0);
        tick(1);
        check("t2_moved_e6", int'(moved), 1);
        tick(3);
        right = 0;
        tick(15);
        check("t2_moves", mcount - m0, 1);
        check("t2_x", int'(x_topleft), 96);
        check("t2_cell", int'(cell_id), 1);

        // 3: held down with auto-repeat
        do_reset();
        m0 = mcount;
        down = 1; tick(60); down = 0; tick(30);
        check("t3_moves", mcount - m0, 6);
        check("t3_y", int'(y_topleft), 240);
        check("t3_cell", int'(cell_id), 96);

        // 4: edge saturation
        do_reset();
        m0 = mcount;
        left = 1; tick(8); left = 0; tick(8);
        up = 1; tick(8); up = 0; tick(8);
        check("t4_corner_moves", mcount - m0, 0);
        check("t4_corner_cell", int'(cell_id), 0);
        right = 1; tick(150); right = 0; tick(10);
        check("t4_x15", int'(x_topleft), 544);
        m0 = mcount;
        right = 1; tick(10); right = 0; tick(10);
        check("t4_edge_moves", mcount - m0, 0);
        check("t4_edge_x", int'(x_topleft), 544);
        check("t4_edge_cell", int'(cell_id), 15);

        // 5: simultaneous right and up
        do_reset();
        m0 = mcount;
        right = 1; up = 1; tick(12); right = 0; up = 0; tick(10);
        check("t5_moves", mcount - m0, 1);
        check("t5_cell", int'(cell_id), 1);
        check("t5_y", int'(y_topleft), 48);

        // 6: flip with and without enable, reset mid-repeat
        do_reset();
        f0 = fcount;
        flip = 1; tick(8); flip = 0; tick(8);
        check("t6_flips", fcount - f0, 1);
        check("t6_cell", int'(cell_id), 0);
        enable = 0;
        f0 = fcount; m0 = mcount;
        flip = 1; right = 1; tick(8); flip = 0; right = 0; tick(8);
        enable = 1;
        check("t6_dis_flips", fcount - f0, 0);
        check("t6_dis_moves", mcount - m0, 0);
        check("t6_dis_cell", int'(cell_id), 0);
        down = 1; tick(40);
        check("t6_pre_rst_cell", int'(cell_id), 48);
        reset = 1; tick(1);
        check("t6_rst_y", int'(y_topleft), 48);
        check("t6_rst_cell", int'(cell_id), 0);
        check("t6_rst_moved", int'(moved), 0);
        reset = 0;
        m0 = mcount;
        tick(14); down = 0; tick(10);
        check("t6_post_moves", mcount - m0, 1);
        check("t6_post_y", int'(y_topleft), 80);
        check("t6_post_cell", int'(cell_id), 16);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cursor_input_ctrl.md
# cursor_input_ctrl

Upstream stage of the Minesweeper top level. It conditions the five raw push-buttons (right, left, up, down, flip): two-flop synchronizer, then debounce, then edge detect, with auto-repeat on held direction buttons. It keeps the cursor's grid position and drives the `x_topleft`/`y_topleft`/flip inputs that the processor uses for game input. Outputs are registered and change only on `clock` edges.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a synchronized input must differ from its stable value before the stable value flips (≥2).
- REPEAT_DELAY, 40000000: cycles a direction must be held after its first move before auto-repeat starts.
- REPEAT_RATE, 15000000: cycles between auto-repeat moves.
- GRID_COLS, 16 / GRID_ROWS, 12: board size in cells.
- CELL_PX, 32: cell pitch in pixels.
- X0, 64 / Y0, 48: pixel origin of cell (0,0).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- right, left, up, down, flip  in  1 each  raw asynchronous buttons, active-high
- enable  in  1  low freezes the cursor and suppresses flip (e.g. game over)
- x_topleft  out  10  X0 + col*CELL_PX
- y_topleft  out  9  Y0 + row*CELL_PX
- cell_id  out  8  row*GRID_COLS + col
- flip_pulse  out  1  one-cycle pulse per debounced flip press
- moved  out  1  one-cycle pulse on the cycle the position outputs change

## Operation
- Per button: sync1→sync2, then stable reg plus a counter. If sync2 == stable, the counter clears. Otherwise the counter increments. When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, stable takes sync2 and the counter clears. A press event is stable rising 0→1.
- Direction FSM (shared), states IDLE, DELAY, REPEAT:
  - IDLE: on any direction press event, latch active_dir, issue one move, load the timer with REPEAT_DELAY-1, go to DELAY.
  - DELAY: the timer counts down. At 0, issue a move, load REPEAT_RATE-1, go to REPEAT.
  - REPEAT: at 0, issue a move and reload REPEAT_RATE-1.
  - DELAY/REPEAT: if active_dir's stable value drops, go to IDLE with no move. Press events on other directions are ignored until IDLE.
- Simultaneous press events in IDLE: priority right > left > down > up; only one direction is latched.
- Move: col/row step by ±1 and saturate at 0 and GRID_COLS-1 / GRID_ROWS-1 (no wrap). A move blocked at an edge does not assert `moved`; the FSM still advances.
- Positions are computed in registers (x/y by add of CELL_PX per step, cell_id by ±1 / ±GRID_COLS). No multipliers. All stay consistent with col/row.
- flip_pulse = flip press event AND enable. No auto-repeat on flip.
- enable low: moves are discarded (position held, moved=0), flip_pulse=0. The debouncers and FSM keep running.
- Reset values: col=row=0, x_topleft=X0, y_topleft=Y0, cell_id=0, flip_pulse=0, moved=0, all sync/stable regs 0, counters 0, FSM IDLE.
- Reset mid-hold: state returns to the reset values. A button still held after reset is re-debounced and produces a fresh press event (stable resets to 0).

## Timing
- Raw input high is first sampled at edge E. sync2 is high after E+1. Stable is high after E+1+DEBOUNCE_CYCLES. The press event is combinational that cycle. col/row/x/y/cell_id/moved update at edge E+2+DEBOUNCE_CYCLES.
- flip_pulse asserts for exactly one cycle, at the same edge as a move would.
- After the first move, the next move occurs REPEAT_DELAY cycles later, then every REPEAT_RATE cycles while held.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no event.
- At most one position change per cycle.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, defaults otherwise.
1. Reset, then idle 10 cycles -> x_topleft=64, y_topleft=48, cell_id=0, flip_pulse=0, moved=0.
2. Press right for 2 cycles (glitch), then right for 10 cycles and release -> glitch ignored; exactly one move at E+6; x_topleft=96, cell_id=1, moved high for one cycle.
3. Hold down for 60 cycles from row 0 -> moves at t, t+20, t+28, t+36, t+44, t+52; final row 6, y_topleft=240, cell_id=96. Release -> no further moves.
4. From (0,0), press left and up once each -> position unchanged, moved never asserts. From col 15 press right -> col stays 15, x_topleft=544.
5. Press right and up in the same cycle -> only right moves (col 0→1). Up is ignored while right is held.
6. Press flip with enable=1 -> one flip_pulse, cell_id unchanged. With enable=0, press flip and right -> no flip_pulse, no move. Assert reset while holding down in REPEAT -> outputs go to reset values next edge; the held button re-debounces and moves once.
